// File: rtl/stream_mux_pkt.sv
// stream_mux_pkt: N:1 packet-aware stream multiplexer with a registered output.
// A channel is chosen at packet start and held until its last beat is taken.
// Optional build macro STREAM_MUX_PKT_RR_ARB_EN: when defined, the channel is
// picked by a round-robin search starting after the previous grant and sel is
// ignored; when undefined, sel picks the channel at packet start.
module stream_mux_pkt #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH-1:0]         in_last,
  output logic [NCH-1:0]         in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       gnt,
  output logic                   locked
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic [SEL_W-1:0] gnt_reg;
  logic             locked_reg;

  logic             load_en;
  logic [SEL_W-1:0] cur;
  logic             cur_ok;
  logic [WIDTH-1:0] cur_data;
  logic             cur_valid;
  logic             cur_last;
  logic             accept;

  logic [WIDTH-1:0] chan_data [NCH];

  // Split the flat data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_split
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The output register can take a beat when empty or draining this cycle.
  assign load_en = !out_valid_reg || out_ready;

`ifdef STREAM_MUX_PKT_RR_ARB_EN
  logic             rr_found;
  logic [SEL_W-1:0] rr_pick;
  int               rr_idx;

  // Round-robin search: first valid channel after the previous grant, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      rr_idx = (int'(gnt_reg) + k) % NCH;
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx[SEL_W-1:0];
      end
    end
  end
`endif

  // Channel in use: the locked grant mid-packet, otherwise the new request.
  always_comb begin
    cur    = '0;
    cur_ok = 1'b0;
    if (state_reg == LOCK) begin
      cur    = gnt_reg;
      cur_ok = 1'b1;
    end else begin
`ifdef STREAM_MUX_PKT_RR_ARB_EN
      cur    = rr_pick;
      cur_ok = rr_found;
`else
      cur    = sel;
      cur_ok = (int'(sel) < NCH);
`endif
    end
  end

  // Pick data, valid and last of the channel in use.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL_W'(i) == cur) begin
        cur_data  = chan_data[i];
        cur_valid = in_valid[i];
        cur_last  = in_last[i];
      end
    end
  end

  // Only the channel in use sees ready; nothing is ready while in reset.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && load_en && cur_ok && (SEL_W'(gi) == cur);
    end
  endgenerate

  assign accept = rst_n && load_en && cur_ok && cur_valid;

  // Output register and packet lock state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      gnt_reg       <= '0;
      locked_reg    <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid_reg <= accept;
        if (accept) begin
          out_data_reg <= cur_data;
          out_last_reg <= cur_last;
        end
      end
      if (accept) begin
        case (state_reg)
          IDLE: begin
            gnt_reg <= cur;
            if (!cur_last) begin
              state_reg  <= LOCK;
              locked_reg <= 1'b1;
            end
          end
          LOCK: begin
            if (cur_last) begin
              state_reg  <= IDLE;
              locked_reg <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign gnt       = gnt_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_stream_mux_pkt.sv
// Randomised scoreboard bench for stream_mux_pkt (NCH=3 so sel=3 is out of range).
module tb_stream_mux_pkt;
  localparam int WIDTH = 8;
  localparam int NCH   = 3;
  localparam int SEL_W = 2;
  localparam int NCYC  = 4000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [SEL_W-1:0]     sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic [SEL_W-1:0]     gnt;
  logic                 locked;

  always #5 clk = ~clk;

  stream_mux_pkt #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .gnt(gnt), .locked(locked)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb_q[$];
  int tests = 0;
  int fails = 0;

  // Producer state: each channel emits packets of random length 1..4.
  int               p_len  [NCH];
  int               p_pos  [NCH];
  logic [WIDTH-1:0] p_data [NCH];

  // Reference model: packet owner (-1 = none), last grant, output occupancy.
  int owner = -1;
  int mgnt  = 0;
  bit mov   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus and reference model.
  initial begin
    int          served;
    logic [NCH-1:0] exp_ready;
    bit          acc;
    bit          blast;
    int          bp_mode;
    rst_n     = 1'b0;
    sel       = 2'd2;
    out_ready = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    bp_mode   = 0;
    for (int i = 0; i < NCH; i++) begin
      p_len[i]  = $urandom_range(1, 4);
      p_pos[i]  = 0;
      p_data[i] = WIDTH'($urandom);
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 3) rst_n = 1'b0;
      else if (cyc >= NCYC - 12) rst_n = 1'b1;
      else rst_n = ($urandom_range(0, 249) != 0);
      if (cyc % 16 == 0) bp_mode = $urandom_range(0, 2);
      if (cyc >= NCYC - 12) out_ready = 1'b1;
      else if (bp_mode == 0) out_ready = 1'b1;
      else if (bp_mode == 1) out_ready = ($urandom_range(0, 1) == 1);
      else out_ready = ((cyc % 16) >= 4);
      if ($urandom_range(0, 3) == 0) sel = SEL_W'($urandom_range(0, 3));
      for (int i = 0; i < NCH; i++) begin
        if (cyc < 3) in_valid[i] = 1'b1;
        else if (cyc >= NCYC - 12) in_valid[i] = 1'b0;
        else in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i*WIDTH +: WIDTH] = p_data[i];
        in_last[i] = (p_pos[i] == p_len[i] - 1);
      end
      #1;
      served = -1;
      if (rst_n) begin
        if (owner >= 0) served = owner;
        else begin
`ifdef STREAM_MUX_PKT_RR_ARB_EN
          for (int k = 1; k <= NCH; k++)
            if (served < 0 && in_valid[(mgnt + k) % NCH]) served = (mgnt + k) % NCH;
`else
          if (int'(sel) < NCH) served = int'(sel);
`endif
        end
      end
      exp_ready = '0;
      if (served >= 0 && (!mov || out_ready)) exp_ready[served] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(mov));
      check("gnt", 32'(gnt), 32'(mgnt));
      check("locked", 32'(locked), 32'(owner >= 0));
      if (cyc == 2) begin
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
      end
      acc   = (served >= 0) && exp_ready[served] && in_valid[served];
      blast = (served >= 0) && in_last[served];
      @(posedge clk);
      if (!rst_n) begin
        owner = -1;
        mov   = 1'b0;
        mgnt  = 0;
        sb_q.delete();
      end else begin
        if (acc) begin
          sb_q.push_back({p_data[served], blast});
          if (owner < 0) mgnt = served;
          owner = blast ? -1 : served;
          p_pos[served]++;
          p_data[served] = WIDTH'($urandom);
          if (p_pos[served] == p_len[served]) begin
            p_pos[served] = 0;
            p_len[served] = $urandom_range(1, 4);
          end
        end
        if (!mov || out_ready) mov = acc;
      end
    end
    @(negedge clk);
    #3;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: pops the expected beat whenever the consumer takes one.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat at %0t", out_data, $time);
        end else begin
          e = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

endmodule

// File: doc/stream_mux_pkt.md
Name: stream_mux_pkt

Overview:
Parametrised N:1 packet-aware stream multiplexer. It is the registered, handshaked successor to the team's combinational 2:1 select muxes.
- Selects one of NCH valid/ready input channels and forwards its beats through a single output register.
- Holds the selection for the whole packet, from the first beat to the beat with last set.
- Sits between multiple producers and a single shared consumer port.

Parameters:
WIDTH, 8, data bits per channel beat
NCH, 4, number of input channels (2..16); localparam SEL_W = max(1, $clog2(NCH))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
sel  input  SEL_W  channel request, sampled only at packet start
in_data  input  NCH*WIDTH  channel i data at [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_last  input  NCH  per-channel end-of-packet flag
in_ready  output  NCH  per-channel ready (combinational)
out_data  output  WIDTH  registered data
out_valid  output  1  registered valid
out_last  output  1  registered last
out_ready  input  1  consumer ready
gnt  output  SEL_W  currently locked channel (registered)
locked  output  1  high while in LOCK state

Behaviour:
- Reset (clk edge with rst_n=0): out_valid=0, out_data=0, out_last=0, gnt=0, locked=0, state=IDLE.
- Reset dominates every other event. A packet in progress is abandoned; no flush.
- load_en = !out_valid || out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle.
- Channel in use, cur:
  - IDLE: cur = sel.
  - LOCK: cur = gnt; sel is ignored.
- in_ready[i] = load_en && state-valid(cur) && (i == cur). All other bits are 0.
- In IDLE, if sel >= NCH, no channel is served and in_ready = 0.
- A beat is accepted when in_valid[cur] && in_ready[cur]. At the next edge:
  - out_data = in_data[cur]
  - out_last = in_last[cur]
  - out_valid = 1
- If load_en holds and no beat is accepted, out_valid clears to 0. out_data and out_last hold their values.
- Latency is 1 cycle from input accept to out_valid.
- Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, the output register holds and all in_ready are 0.
- FSM:
  - IDLE -> LOCK: a beat is accepted with in_last[cur]=0. At that edge gnt <= cur and locked <= 1.
  - IDLE -> IDLE: a beat is accepted with in_last=1 (single-beat packet). gnt <= cur; locked stays 0.
  - LOCK -> IDLE: a beat is accepted with in_last[gnt]=1. locked <= 0; gnt holds.
  - LOCK -> LOCK: otherwise. Bubbles on the locked channel (in_valid=0) do not release the lock.
- A change of sel during LOCK has no effect until the cycle after the last beat is accepted.
- Simultaneous drain and load in one cycle (out_valid=1, out_ready=1, accept) is a normal pass-through with no bubble.
- Data from unselected channels never reaches out_data.

Optional Feature:
Macro: STREAM_MUX_PKT_RR_ARB_EN
- Defined:
  - sel is ignored.
  - At packet start (IDLE), cur = first channel with in_valid set, searching from (gnt+1) mod NCH upward and wrapping.
  - If no channel is valid, no beat is accepted.
  - After reset the search starts at channel 1, because gnt=0.
  - Lock/release rules are unchanged.
- Not defined: sel-driven selection exactly as above; no arbiter logic is synthesised.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0, locked=0. Release reset with sel=2 and no valid -> out_valid stays 0.
2. Single beats: sel=1, ch1 sends 0xA5 with last=1, out_ready=1 -> in_ready=4'b0010, out_data=0xA5 and out_last=1 one cycle later, gnt=1, locked=0.
3. Packet lock: sel=0, ch0 sends 0x10,0x11,0x12 with last on 0x12; sel switches to 3 after the first beat and ch3 stays valid -> output 0x10,0x11,0x12 in order. Channel 3's first beat is output only after 0x12, with no extra bubble.
4. Backpressure: hold out_ready=0 for 4 cycles mid-packet -> out_data holds its value, in_ready=0. Then set out_ready=1 -> stream resumes with no beat lost or duplicated.
5. Reset mid-packet: assert rst_n=0 after the 2nd of 4 beats -> next cycle locked=0 and out_valid=0. A new packet on sel=2 is accepted normally afterwards.
6. Out-of-range select or RR (with STREAM_MUX_PKT_RR_ARB_EN):
   - Without the macro: NCH=3, sel=3 -> in_ready=0, no output.
   - With the macro: all 4 channels send one-beat packets continuously -> grant order 1,2,3,0,1.
